// File: rtl/vscpu_mmio_pkg.sv
// Shared constants for the VSCPU memory responder: MMIO window layout and STATUS bit positions.
package vscpu_mmio_pkg;

  localparam int WORD_W     = 32;
  localparam int MMIO_OFF_W = 4;

  localparam logic [MMIO_OFF_W-1:0] OFF_TX_DATA = 4'h0;
  localparam logic [MMIO_OFF_W-1:0] OFF_STATUS  = 4'h1;
  localparam logic [MMIO_OFF_W-1:0] OFF_CYCLE   = 4'h2;
  localparam logic [MMIO_OFF_W-1:0] OFF_RX_DATA = 4'h3;

  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_MBOX_BIT  = 15;
  localparam int ST_OVF_BIT   = 16;

endpackage

// File: rtl/vscpu_tx_fifo.sv
// First-word-fall-through FIFO for the outbound TX stream; a push while full is taken only if a pop frees the slot.
module vscpu_tx_fifo
  import vscpu_mmio_pkg::*;
#(
  parameter int FIFO_LOG2 = 3,
  parameter int DATA_W    = WORD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_W-1:0]    din_i,
  input  logic                 pop_i,
  output logic [DATA_W-1:0]    dout_o,
  output logic [FIFO_LOG2:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int                 DEPTH   = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so tx_data reads 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vscpu_mem_responder.sv
// VSCPU memory-port responder: registered-read block RAM plus a 16-word MMIO window
// (TX FIFO, STATUS, CYCLE counter, RX mailbox) at the top of the address space.
module vscpu_mem_responder
  import vscpu_mmio_pkg::*;
#(
  parameter int SIZE      = 14,
  parameter int FIFO_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SIZE-1:0]   addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              tx_valid,
  output logic [WORD_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [WORD_W-1:0] rx_data,
  output logic              rx_ready
);

  localparam int RAM_WORDS = 1 << SIZE;

  logic [WORD_W-1:0] ram_q [RAM_WORDS];

  logic                  mmio_hit;
  logic [MMIO_OFF_W-1:0] off;
  logic                  wr_tx, wr_status, wr_cycle, wr_rx;
  logic                  tx_pop, fifo_full, fifo_empty;
  logic [FIFO_LOG2:0]    fifo_count;

  logic [WORD_W-1:0] dout_q, dout_d;
  logic [WORD_W-1:0] cycle_q, cycle_d;
  logic              ovf_q, ovf_d;
  logic              mbox_full_q, mbox_full_d;
  logic [WORD_W-1:0] mbox_data_q, mbox_data_d;
  logic [WORD_W-1:0] status, mmio_rdata;

  assign mmio_hit  = &addr[SIZE-1:MMIO_OFF_W];
  assign off       = addr[MMIO_OFF_W-1:0];
  assign wr_tx     = we && mmio_hit && (off == OFF_TX_DATA);
  assign wr_status = we && mmio_hit && (off == OFF_STATUS);
  assign wr_cycle  = we && mmio_hit && (off == OFF_CYCLE);
  assign wr_rx     = we && mmio_hit && (off == OFF_RX_DATA);

  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !mbox_full_q;
  assign dout     = dout_q;

  vscpu_tx_fifo #(
    .FIFO_LOG2 (FIFO_LOG2),
    .DATA_W    (WORD_W)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_tx),
    .din_i   (din),
    .pop_i   (tx_pop),
    .dout_o  (tx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    status                  = '0;
    status[FIFO_LOG2:0]     = fifo_count;
    status[ST_EMPTY_BIT]    = fifo_empty;
    status[ST_FULL_BIT]     = fifo_full;
    status[ST_MBOX_BIT]     = mbox_full_q;
    status[ST_OVF_BIT]      = ovf_q;

    mmio_rdata = '0;
    case (off)
      OFF_STATUS:  mmio_rdata = status;
      OFF_CYCLE:   mmio_rdata = cycle_q;
      OFF_RX_DATA: mmio_rdata = mbox_full_q ? mbox_data_q : '0;
      default:     mmio_rdata = '0;
    endcase

    dout_d = mmio_hit ? mmio_rdata : ram_q[addr];

    cycle_d = wr_cycle ? din : cycle_q + 32'd1;

    // A dropped push must win over a clear landing in the same cycle.
    ovf_d = ovf_q;
    if (wr_tx && fifo_full && !tx_pop)        ovf_d = 1'b1;
    else if (wr_status && din[ST_OVF_BIT])    ovf_d = 1'b0;

    mbox_full_d = mbox_full_q;
    mbox_data_d = mbox_data_q;
    if (rx_valid && !mbox_full_q) begin
      mbox_full_d = 1'b1;
      mbox_data_d = rx_data;
    end else if (wr_rx) begin
      mbox_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !mmio_hit) ram_q[addr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= '0;
      cycle_q     <= '0;
      ovf_q       <= 1'b0;
      mbox_full_q <= 1'b0;
      mbox_data_q <= '0;
    end else begin
      dout_q      <= dout_d;
      cycle_q     <= cycle_d;
      ovf_q       <= ovf_d;
      mbox_full_q <= mbox_full_d;
      mbox_data_q <= mbox_data_d;
    end
  end

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// Bench for vscpu_mem_responder: directed vector table, reset-mid-drain sequence, random traffic vs a queue model.
module tb_vscpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst, we, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [13:0] addr;
  logic [31:0] din, dout, tx_data, rx_data;

  always #5 clk = ~clk;

  vscpu_mem_responder #(.SIZE(14), .FIFO_LOG2(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, RAM as a sparse array of written words.
  logic [31:0] mq[$];
  logic [31:0] m_ram[int];
  bit          m_ovf, m_mfull, m_known;
  logic [31:0] m_mdata, m_cycle, m_dout;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_mfull = 0; m_mdata = 0; m_cycle = 0; m_dout = 0; m_known = 1;
  endtask

  task automatic model_step(input bit w, input logic [13:0] a, input logic [31:0] d,
                            input bit txr, input bit rxv, input logic [31:0] rxd);
    bit          hit, pop, was_full;
    int          o;
    logic [31:0] st, cyc_next;
    hit = (a[13:4] == 10'h3FF);
    o = int'(a[3:0]);
    pop = (mq.size() != 0) && txr;
    was_full = (mq.size() == 8);
    st = 32'(mq.size());
    st[8] = (mq.size() == 0);
    st[9] = was_full;
    st[15] = m_mfull;
    st[16] = m_ovf;
    if (hit) begin
      m_known = 1;
      case (o)
        1: m_dout = st;
        2: m_dout = m_cycle;
        3: m_dout = m_mfull ? m_mdata : 32'h0;
        default: m_dout = 32'h0;
      endcase
    end else if (m_ram.exists(int'(a))) begin
      m_known = 1;
      m_dout = m_ram[int'(a)];
    end else begin
      m_known = 0;
    end
    cyc_next = m_cycle + 1;
    if (pop) void'(mq.pop_front());
    if (w && hit) begin
      case (o)
        0: if (!was_full || pop) mq.push_back(d); else m_ovf = 1;
        1: if (d[16]) m_ovf = 0;
        2: cyc_next = d;
        default: ;
      endcase
    end
    if (rxv && !m_mfull) begin
      m_mfull = 1;
      m_mdata = rxd;
    end else if (w && hit && o == 3) begin
      m_mfull = 0;
    end
    if (w && !hit) m_ram[int'(a)] = d;
    m_cycle = cyc_next;
  endtask

  task automatic model_check(input string tag);
    if (m_known) chk({tag, "_dout"}, dout, m_dout);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, "_tx_data"}, tx_data, mq[0]);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(!m_mfull));
  endtask

  task automatic cycle(input bit w, input logic [13:0] a, input logic [31:0] d,
                       input bit txr, input bit rxv, input logic [31:0] rxd);
    we = w; addr = a; din = d; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    @(posedge clk);
    #1;
    model_step(w, a, d, txr, rxv, rxd);
  endtask

  typedef struct {
    bit          we;
    logic [13:0] addr;
    logic [31:0] din;
    bit          txr;
    bit          rxv;
    logic [31:0] rxd;
    bit          chk_dout;
    logic [31:0] dout;
    bit          txv;
    logic [31:0] txd;
    bit          rxr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit w, logic [13:0] a, logic [31:0] d, bit txr, bit rxv,
                             logic [31:0] rxd, bit cd, logic [31:0] ed, bit txv,
                             logic [31:0] txd, bit rxr);
    vec_t r;
    r.we = w; r.addr = a; r.din = d; r.txr = txr; r.rxv = rxv; r.rxd = rxd;
    r.chk_dout = cd; r.dout = ed; r.txv = txv; r.txd = txd; r.rxr = rxr;
    return r;
  endfunction

  initial begin
    logic [31:0] drain_dout [8];
    logic [31:0] drain_txd  [8];
    drain_dout = '{32'h208, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    drain_txd  = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'hAA, 32'h0};

    // RAM write, read, read-before-write
    tbl.push_back(v(1, 14'h0005, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 14'h0005, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(v(1, 14'h0005, 32'h1, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(v(0, 14'h0005, 32'h0, 0, 0, 0, 1, 32'h1, 0, 0, 1));
    // TX push 1,2,3 then drain
    tbl.push_back(v(1, 14'h3FF0, 32'h1, 0, 0, 0, 1, 32'h0, 1, 32'h1, 1));
    tbl.push_back(v(1, 14'h3FF0, 32'h2, 0, 0, 0, 1, 32'h0, 1, 32'h1, 1));
    tbl.push_back(v(1, 14'h3FF0, 32'h3, 0, 0, 0, 1, 32'h0, 1, 32'h1, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 0, 0, 0, 1, 32'h3, 1, 32'h1, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 1, 0, 0, 1, 32'h3, 1, 32'h2, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 1, 0, 0, 1, 32'h2, 1, 32'h3, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 1, 0, 0, 1, 32'h1, 0, 0, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 0, 0, 0, 1, 32'h100, 0, 0, 1));
    // Overflow: nine pushes into eight slots
    for (int i = 0; i < 9; i++)
      tbl.push_back(v(1, 14'h3FF0, 32'h10 + i, 0, 0, 0, 1, 32'h0, 1, 32'h10, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 0, 0, 0, 1, 32'h10208, 1, 32'h10, 1));
    tbl.push_back(v(1, 14'h3FF1, 32'h10000, 0, 0, 0, 1, 32'h10208, 1, 32'h10, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 0, 0, 0, 1, 32'h208, 1, 32'h10, 1));
    // Push while full with simultaneous pop
    tbl.push_back(v(1, 14'h3FF0, 32'hAA, 1, 0, 0, 1, 32'h0, 1, 32'h11, 1));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 0, 0, 0, 1, 32'h208, 1, 32'h11, 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(0, 14'h3FF1, 32'h0, 1, 0, 0, 1, drain_dout[i], i < 7, drain_txd[i], 1));
    // CYCLE load then two reads
    tbl.push_back(v(1, 14'h3FF2, 32'd100, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 14'h0005, 32'h0, 0, 0, 0, 1, 32'h1, 0, 0, 1));
    tbl.push_back(v(0, 14'h3FF2, 32'h0, 0, 0, 0, 1, 32'd101, 0, 0, 1));
    tbl.push_back(v(0, 14'h3FF2, 32'h0, 0, 0, 0, 1, 32'd102, 0, 0, 1));
    // RX mailbox
    tbl.push_back(v(0, 14'h3FF3, 32'h0, 0, 1, 32'h55, 1, 32'h0, 0, 0, 0));
    tbl.push_back(v(0, 14'h3FF3, 32'h0, 0, 0, 0, 1, 32'h55, 0, 0, 0));
    tbl.push_back(v(0, 14'h3FF1, 32'h0, 0, 0, 0, 1, 32'h8100, 0, 0, 0));
    tbl.push_back(v(1, 14'h3FF3, 32'h0, 0, 0, 0, 1, 32'h55, 0, 0, 1));
    tbl.push_back(v(0, 14'h3FF3, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0, 1));
    // Reserved window word
    tbl.push_back(v(1, 14'h3FF7, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h0, 0, 0, 1));
    tbl.push_back(v(0, 14'h3FF7, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0, 1));

    rst = 1; we = 0; addr = 0; din = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    #2;
    chk("reset_dout", dout, 32'h0);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_tx_data", tx_data, 32'h0);
    chk("reset_rx_ready", 32'(rx_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
      if (tbl[i].chk_dout) chk($sformatf("row%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("row%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].txv));
      if (tbl[i].txv) chk($sformatf("row%0d_tx_data", i), tx_data, tbl[i].txd);
      chk($sformatf("row%0d_rx_ready", i), 32'(rx_ready), 32'(tbl[i].rxr));
    end

    // Reset asserted mid-drain with four words queued and the mailbox full
    for (int i = 0; i < 4; i++) cycle(1, 14'h3FF0, 32'h100 + i, 0, i == 0, 32'h77);
    cycle(0, 14'h3FF1, 32'h0, 1, 0, 0);
    model_check("predrain");
    #3;
    rst = 1;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
    chk("midrst_dout", dout, 32'h0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    chk("postrst_tx_valid", 32'(tx_valid), 32'h0);
    cycle(0, 14'h3FF2, 32'h0, 1, 0, 0);
    chk("postrst_cycle0", dout, 32'h0);
    chk("postrst_tx_valid2", 32'(tx_valid), 32'h0);
    cycle(0, 14'h3FF2, 32'h0, 1, 0, 0);
    chk("postrst_cycle1", dout, 32'h1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int          pick;
      bit          w, txr, rxv;
      logic [13:0] a;
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1, 2: a = 14'($urandom_range(0, 15));
        3, 4:    a = 14'h3FF0;
        5:       a = 14'h3FF1;
        6:       a = 14'h3FF2;
        7:       a = 14'h3FF3;
        default: a = 14'h3FF0 + 14'($urandom_range(0, 15));
      endcase
      w   = ($urandom_range(0, 1) == 1);
      txr = ($urandom_range(0, 2) == 0);
      rxv = ($urandom_range(0, 1) == 1);
      if (w && a == 14'h3FF3) rxv = 0;
      cycle(w, a, $urandom, txr, rxv, $urandom);
      model_check($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
